// File: rtl/mips_mc_control_unit_if.sv
// Control-unit bus: opcode and flags into the FSM, datapath controls and retire count out.
interface mips_mc_control_unit_if #(
    parameter int unsigned RETIRE_CNT_WIDTH = 32,
    parameter int unsigned MIPS_OP_WIDTH    = 6
);
    logic [MIPS_OP_WIDTH-1:0]    op_i;
    logic                        zero_i;
    logic                        mem_ready_i;
    logic                        pc_en_o;
    logic [1:0]                  pc_source_o;
    logic                        i_or_d_o;
    logic                        mem_read_o;
    logic                        mem_write_o;
    logic                        ir_write_o;
    logic                        reg_dst_o;
    logic                        mem_to_reg_o;
    logic                        reg_write_o;
    logic                        alu_src_a_o;
    logic [1:0]                  alu_src_b_o;
    logic [1:0]                  alu_op_o;
    logic                        illegal_op_o;
    logic [RETIRE_CNT_WIDTH-1:0] retired_o;

    // Control unit side
    modport slave (
        input  op_i, zero_i, mem_ready_i,
        output pc_en_o, pc_source_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, illegal_op_o, retired_o
    );

    // Datapath / environment side
    modport master (
        output op_i, zero_i, mem_ready_i,
        input  pc_en_o, pc_source_o, i_or_d_o, mem_read_o, mem_write_o, ir_write_o,
               reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, illegal_op_o, retired_o
    );
endinterface

// File: rtl/mips_mc_control_unit.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// decodes datapath controls from the current state (plus mem_ready and zero),
// and counts retired instructions.
module mips_mc_control_unit #(
    parameter int unsigned RETIRE_CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    mips_mc_control_unit_if.slave        bus
);
    localparam int unsigned MIPS_OP_WIDTH = 6;

    localparam logic [MIPS_OP_WIDTH-1:0] OP_R    = 6'b000000;
    localparam logic [MIPS_OP_WIDTH-1:0] OP_LW   = 6'b100011;
    localparam logic [MIPS_OP_WIDTH-1:0] OP_SW   = 6'b101011;
    localparam logic [MIPS_OP_WIDTH-1:0] OP_BEQ  = 6'b000100;
    localparam logic [MIPS_OP_WIDTH-1:0] OP_ADDI = 6'b001000;
    localparam logic [MIPS_OP_WIDTH-1:0] OP_J    = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_JUMP      = 4'd11
    } state_e;

    state_e                      state_q, state_d;
    logic [RETIRE_CNT_WIDTH-1:0] retired_q, retired_d;

    logic       pc_write_c;
    logic       pc_write_cond_c;
    logic [1:0] pc_source_c;
    logic       i_or_d_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_dst_c;
    logic       mem_to_reg_c;
    logic       reg_write_c;
    logic       alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic       illegal_op_c;
    logic       retire_c;

    // State and retire-counter registers; reset returns to FETCH asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state and control decode; everything is held at 0 while rst is high
    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        pc_source_c     = 2'b00;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        ir_write_c      = 1'b0;
        reg_dst_c       = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_write_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'b00;
        alu_op_c        = 2'b00;
        illegal_op_c    = 1'b0;
        retire_c        = 1'b0;

        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read_c  = 1'b1;
                    alu_src_b_c = 2'b01;
                    ir_write_c  = bus.mem_ready_i;
                    pc_write_c  = bus.mem_ready_i;
                    if (bus.mem_ready_i) state_d = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_b_c = 2'b11;
                    case (bus.op_i)
                        OP_R:         state_d = S_EXECUTE;
                        OP_LW, OP_SW: state_d = S_MEM_ADDR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_ADDI:      state_d = S_ADDI_EXEC;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            illegal_op_c = 1'b1;
                            state_d      = S_FETCH;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 2'b10;
                    state_d     = (bus.op_i == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    mem_read_c = 1'b1;
                    i_or_d_c   = 1'b1;
                    if (bus.mem_ready_i) state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    mem_to_reg_c = 1'b1;
                    reg_write_c  = 1'b1;
                    retire_c     = 1'b1;
                    state_d      = S_FETCH;
                end
                S_MEM_WRITE: begin
                    mem_write_c = 1'b1;
                    i_or_d_c    = 1'b1;
                    if (bus.mem_ready_i) begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
                S_EXECUTE: begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 2'b00;
                    alu_op_c    = 2'b10;
                    state_d     = S_R_WB;
                end
                S_R_WB: begin
                    reg_dst_c   = 1'b1;
                    reg_write_c = 1'b1;
                    retire_c    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_c     = 1'b1;
                    alu_op_c        = 2'b01;
                    pc_source_c     = 2'b01;
                    pc_write_cond_c = 1'b1;
                    retire_c        = 1'b1;
                    state_d         = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 2'b10;
                    state_d     = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write_c = 1'b1;
                    retire_c    = 1'b1;
                    state_d     = S_FETCH;
                end
                S_JUMP: begin
                    pc_write_c  = 1'b1;
                    pc_source_c = 2'b10;
                    retire_c    = 1'b1;
                    state_d     = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end

        retired_d = retire_c ? retired_q + RETIRE_CNT_WIDTH'(1) : retired_q;
    end

    // Controls are a direct decode of the current state, so they are driven combinationally
    assign bus.pc_en_o      = pc_write_c | (pc_write_cond_c & bus.zero_i);
    assign bus.pc_source_o  = pc_source_c;
    assign bus.i_or_d_o     = i_or_d_c;
    assign bus.mem_read_o   = mem_read_c;
    assign bus.mem_write_o  = mem_write_c;
    assign bus.ir_write_o   = ir_write_c;
    assign bus.reg_dst_o    = reg_dst_c;
    assign bus.mem_to_reg_o = mem_to_reg_c;
    assign bus.reg_write_o  = reg_write_c;
    assign bus.alu_src_a_o  = alu_src_a_c;
    assign bus.alu_src_b_o  = alu_src_b_c;
    assign bus.alu_op_o     = alu_op_c;
    assign bus.illegal_op_o = illegal_op_c;
    assign bus.retired_o    = retired_q;
endmodule

// File: tb/tb_mips_mc_control_unit.sv
// Bench for mips_mc_control_unit: an instruction-level model expands each instruction
// into its per-cycle control words; a monitor compares the DUT against them every cycle.
module tb_mips_mc_control_unit;
    localparam int unsigned RW = 4;

    logic clk;
    logic rst;

    mips_mc_control_unit_if #(.RETIRE_CNT_WIDTH(RW), .MIPS_OP_WIDTH(6)) bif ();

    mips_mc_control_unit #(.RETIRE_CNT_WIDTH(RW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]   exp_w_q[$];
    logic [RW-1:0] exp_r_q[$];
    int unsigned   cnt_m;
    int            n_checks;
    int            n_pass;

    // Expected control word: {pc_en,pc_source,i_or_d,mem_read,mem_write,ir_write,
    //                         reg_dst,mem_to_reg,reg_write,alu_src_a,alu_src_b,alu_op,illegal_op}
    function automatic logic [15:0] mk(input logic pe, input logic [1:0] ps, input logic iod,
                                       input logic mrd, input logic mwr, input logic irw,
                                       input logic rdst, input logic m2r, input logic rw,
                                       input logic sa, input logic [1:0] sb,
                                       input logic [1:0] aop, input logic ill);
        return {pe, ps, iod, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, ill};
    endfunction

    // Drive one cycle of inputs and post its expected outputs to the scoreboard
    task automatic cyc(input logic r, input logic mr, input logic z, input logic [5:0] o,
                       input logic [15:0] w, input logic ret);
        @(posedge clk);
        #1;
        rst             = r;
        bif.mem_ready_i = mr;
        bif.zero_i      = z;
        bif.op_i        = o;
        if (r) cnt_m = 0;
        exp_w_q.push_back(w);
        exp_r_q.push_back(RW'(cnt_m));
        if (ret && !r) cnt_m = (cnt_m + 1) % (1 << RW);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] junk();
        return 6'($urandom_range(0, 63));
    endfunction

    // Fetch with stalls, then decode; returns 1 if the opcode is legal
    task automatic front(input logic [5:0] op, input int stall_f, output logic legal);
        for (int i = 0; i < stall_f; i++)
            cyc(1'b0, 1'b0, rb(), junk(), mk(0, 2'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 0), 1'b0);
        cyc(1'b0, 1'b1, rb(), junk(), mk(1, 2'd0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd1, 2'd0, 0), 1'b0);
        legal = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
                (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
        cyc(1'b0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd3, 2'd0, !legal), 1'b0);
    endtask

    // One complete instruction as seen from the control outputs
    task automatic instr(input logic [5:0] op, input int stall_f, input int stall_m, input logic zb);
        logic legal;
        front(op, stall_f, legal);
        if (legal) begin
            case (op)
                6'b000000: begin
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd2, 0), 0);
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 1, 0, 1, 0, 2'd0, 2'd0, 0), 1);
                end
                6'b100011: begin
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0), 0);
                    for (int i = 0; i < stall_m; i++)
                        cyc(0, 0, rb(), op, mk(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), 0);
                    cyc(0, 1, rb(), op, mk(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), 0);
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0), 1);
                end
                6'b101011: begin
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0), 0);
                    for (int i = 0; i < stall_m; i++)
                        cyc(0, 0, rb(), op, mk(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), 0);
                    cyc(0, 1, rb(), op, mk(0, 2'd0, 1, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), 1);
                end
                6'b000100:
                    cyc(0, rb(), zb, op, mk(zb, 2'd1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0, 2'd1, 0), 1);
                6'b001000: begin
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0), 0);
                    cyc(0, rb(), rb(), op, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 0), 1);
                end
                default:
                    cyc(0, rb(), rb(), op, mk(1, 2'd2, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), 1);
            endcase
        end
    endtask

    function automatic logic [5:0] pick_op();
        logic [5:0] tbl [6];
        tbl[0] = 6'b000000; tbl[1] = 6'b100011; tbl[2] = 6'b101011;
        tbl[3] = 6'b000100; tbl[4] = 6'b001000; tbl[5] = 6'b000010;
        if ($urandom_range(0, 9) == 0) return junk();
        return tbl[$urandom_range(0, 5)];
    endfunction

    // Monitor: every cycle the DUT presents a control word; compare against the scoreboard
    initial begin
        logic [15:0]   ew, aw;
        logic [RW-1:0] er;
        forever begin
            @(negedge clk);
            if (exp_w_q.size() > 0) begin
                ew = exp_w_q.pop_front();
                er = exp_r_q.pop_front();
                aw = {bif.pc_en_o, bif.pc_source_o, bif.i_or_d_o, bif.mem_read_o, bif.mem_write_o,
                      bif.ir_write_o, bif.reg_dst_o, bif.mem_to_reg_o, bif.reg_write_o,
                      bif.alu_src_a_o, bif.alu_src_b_o, bif.alu_op_o, bif.illegal_op_o};
                n_checks++;
                if (aw !== ew)
                    $display("FAIL ctrl t=%0t actual=%b required=%b", $time, aw, ew);
                else
                    n_pass++;
                n_checks++;
                if (bif.retired_o !== er)
                    $display("FAIL retired t=%0t actual=%0d required=%0d", $time, bif.retired_o, er);
                else
                    n_pass++;
                if (bif.mem_read_o === 1'b1 && bif.mem_write_o === 1'b1) begin
                    n_checks++;
                    $display("FAIL rw_exclusive t=%0t actual=11 required=not both", $time);
                end
            end
        end
    end

    // Stimulus: directed cases first, then random instruction streams
    initial begin
        logic legal;
        int   drain;
        n_checks = 0;
        n_pass   = 0;
        cnt_m    = 0;
        rst             = 1'b1;
        bif.mem_ready_i = 1'b1;
        bif.zero_i      = 1'b0;
        bif.op_i        = 6'b0;

        cyc(1, 1, 0, 6'd0, 16'd0, 0);
        cyc(1, 1, 0, 6'd0, 16'd0, 0);

        instr(6'b100011, 0, 0, 0);
        instr(6'b101011, 0, 3, 0);
        instr(6'b000100, 0, 0, 1);
        instr(6'b000100, 0, 0, 0);
        instr(6'b111111, 0, 0, 0);
        instr(6'b000010, 0, 0, 0);
        instr(6'b000000, 2, 0, 0);
        instr(6'b001000, 1, 0, 0);

        // Reset while LW is waiting in MEM_READ
        front(6'b100011, 1, legal);
        cyc(0, rb(), rb(), 6'b100011, mk(0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 0), 0);
        cyc(0, 0, rb(), 6'b100011, mk(0, 2'd0, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 0), 0);
        cyc(1, 1, 1, 6'b100011, 16'd0, 0);
        cyc(1, 1, 1, 6'b100011, 16'd0, 0);

        // Counter wrap: all-ones after 15 retires, then an R-type rolls it to 0
        for (int i = 0; i < 15; i++) instr(6'b001000, 0, 0, 0);
        instr(6'b000000, 0, 0, 0);
        instr(6'b000010, 0, 0, 0);

        for (int i = 0; i < 120; i++)
            instr(pick_op(), $urandom_range(0, 2), $urandom_range(0, 3), rb());

        drain = 0;
        while (exp_w_q.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        if (exp_w_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain actual=%0d required=0 pending", exp_w_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
